lowpan_packetiser: RTL
======================

LOWPAN_PACKETISER -- requirements
Module: lowpan_packetiser

Interface
REQ-001 SHALL have parameters, one per line:
  PAYLOAD_LEN, 8, max payload bytes per packet (1..255).
  FIFO_DEPTH, 16, input buffer depth in bytes (power of 2, >= PAYLOAD_LEN).
  NODE_ID, 8'h01, node address byte placed in the header.
  TIMEOUT, 64, idle cycles before a partial payload is flushed (0 = flush disabled).
REQ-002 SHALL have ports, one per line:
  clk  in  1  system clock.
  rst  in  1  reset.
  data_in  in  8  sensor byte.
  data_valid  in  1  data_in valid this cycle.
  data_ready  out  1  byte accepted when data_valid & data_ready.
  tx_data  out  8  byte to radio.
  send  out  1  one-cycle strobe; tx_data valid.
  radio_busy  in  1  radio cannot accept a byte.
  packet_valid  out  1  a packet is being emitted.
  overflow  out  1  one-cycle pulse: byte dropped.
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL buffer accepted bytes in a FIFO of FIFO_DEPTH; data_ready = not full.
REQ-005 SHALL pulse overflow and drop the byte when data_valid is high while full.
REQ-006 SHALL accept input bytes in every state, including during transmission.
REQ-007 FSM states SHALL be IDLE, HDR, PAYLOAD, CSUM.
REQ-008 IDLE->HDR SHALL occur when the registered FIFO count >= PAYLOAD_LEN, or when TIMEOUT != 0, count > 0, and the idle counter reaches TIMEOUT.
REQ-009 On IDLE->HDR, the block SHALL latch len = min(count, PAYLOAD_LEN).
REQ-010 The idle counter SHALL clear on every accepted byte and outside IDLE, and SHALL saturate at TIMEOUT.
REQ-011 Packet byte order SHALL be:
  8'h41 (dispatch).
  NODE_ID.
  seq.
  len.
  len payload bytes, popped from the FIFO in order.
  checksum = XOR of all preceding packet bytes.
REQ-012 seq SHALL be an 8-bit counter, incremented after each checksum send, wrapping 255->0.
REQ-013 send SHALL assert only in a cycle where radio_busy = 0, the FSM has a byte pending, and send was low in the previous cycle (minimum one-cycle gap between strobes).
REQ-014 tx_data SHALL be registered and stable while a byte is pending, regardless of radio_busy.
REQ-015 A FIFO pop SHALL occur only in the cycle a payload byte's send asserts.
REQ-016 packet_valid SHALL rise with the IDLE->HDR transition, stay high through the checksum send cycle, then fall.
REQ-017 CSUM->IDLE SHALL occur after the checksum send; a new trigger SHALL be evaluated from the following cycle.
REQ-018 Latency: with radio_busy low, the first send SHALL occur 2 cycles after the edge that writes the PAYLOAD_LEN-th byte.
REQ-019 Simultaneous FIFO push and pop SHALL leave the count unchanged, including when the FIFO is full.
REQ-020 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 On rst, the block SHALL return to IDLE and empty the FIFO.
REQ-022 On rst, seq, the idle counter and the checksum SHALL be 0.
REQ-023 On rst: tx_data = 8'h00; send, packet_valid and overflow = 0; data_ready = 1.
REQ-024 rst mid-packet SHALL abandon the packet; no further send SHALL occur until a new trigger.

Structure
REQ-025 A shared package SHALL hold: DISPATCH = 8'h41, the FSM state encoding, and the header length constant 4.
REQ-026 The FIFO SHALL be a separate sub-module, pkt_fifo, parameterised in width and depth and exposing count, full and empty.

Verification (PAYLOAD_LEN=4, NODE_ID=8'h12, FIFO_DEPTH=8, TIMEOUT=16)
REQ-027 Full packet: bytes 01,02,03,04, radio idle -> sends 41,12,00,04,01,02,03,04,53; packet_valid spans them; seq becomes 01.
REQ-028 Timeout flush: single byte AB after the first packet, then no input -> after 16 idle cycles sends 41,12,01,01,AB,F8.
REQ-029 Backpressure: radio_busy held high for 20 cycles mid-payload -> no send, tx_data stable; resumes in order once busy drops.
REQ-030 Overflow: 9 bytes pushed while busy mid-packet with the FIFO empty -> data_ready falls after the 8th; overflow pulses once on the 9th; the 9th byte is never sent.
REQ-031 Wrap: 256 packets sent -> the seq byte of packet 257 is 00; all checksums are correct.
REQ-032 Reset mid-PAYLOAD: assert rst for 1 cycle -> outputs hold reset values; the next 4 bytes produce a packet with seq 00.

Source files
------------

// File: rtl/lowpan_packetiser_pkg.sv
// Shared constants and FSM encoding for the 6LoWPAN-style sensor packetiser.
package lowpan_packetiser_pkg;

  localparam logic [7:0]  DISPATCH = 8'h41;
  localparam int unsigned HDR_LEN  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPayload,
    StCsum
  } pkt_state_e;

endpackage

// File: rtl/pkt_fifo.sv
// Byte buffer with first-word fall-through read port, count, full and empty flags.
module pkt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push against a full buffer still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lowpan_packetiser.sv
// Buffers sensor bytes and frames them as dispatch/node/seq/len/payload/xor-checksum packets.
module lowpan_packetiser
  import lowpan_packetiser_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [7:0]  NODE_ID     = 8'h01,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] tx_data,
  output logic       send,
  input  logic       radio_busy,
  output logic       packet_valid,
  output logic       overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]    fifo_rdata;

  pkt_state_e    state_q, state_d;
  logic          pending_q, pending_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [1:0]    hdr_idx_q, hdr_idx_d;
  logic [7:0]    remain_q, remain_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    seq_q, seq_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          send_prev_q, overflow_q;
  logic [31:0]   count_ext;
  logic          trig_full, trig_timeout;

  assign fifo_push  = data_valid & ~fifo_full;
  assign data_ready = ~fifo_full;

  pkt_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign count_ext    = 32'(fifo_count);
  assign trig_full    = (count_ext >= PAYLOAD_LEN);
  assign trig_timeout = (TIMEOUT != 0) && !fifo_empty && (idle_cnt_q == IW'(TIMEOUT));

  // A byte is presented only when pending, the radio is free, and the previous cycle was quiet.
  assign send         = pending_q & ~radio_busy & ~send_prev_q;
  assign tx_data      = tx_data_q;
  assign packet_valid = (state_q != StIdle);
  assign overflow     = overflow_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q != StIdle) || fifo_push) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IW'(TIMEOUT)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tx_data_d = tx_data_q;
    hdr_idx_d = hdr_idx_q;
    remain_d  = remain_q;
    len_d     = len_q;
    csum_d    = csum_q;
    seq_d     = seq_q;
    fifo_pop  = 1'b0;

    if (send) csum_d = csum_q ^ tx_data_q;

    unique case (state_q)
      StIdle: begin
        if (trig_full || trig_timeout) begin
          state_d   = StHdr;
          len_d     = trig_full ? 8'(PAYLOAD_LEN) : 8'(count_ext);
          tx_data_d = DISPATCH;
          pending_d = 1'b1;
          hdr_idx_d = 2'd0;
          csum_d    = 8'h00;
        end
      end
      StHdr: begin
        if (send) begin
          if (hdr_idx_q == 2'(HDR_LEN - 1)) begin
            state_d   = StPayload;
            pending_d = 1'b0;
            remain_d  = len_q;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
            unique case (hdr_idx_q)
              2'd0:    tx_data_d = NODE_ID;
              2'd1:    tx_data_d = seq_q;
              default: tx_data_d = len_q;
            endcase
          end
        end
      end
      StPayload: begin
        // The FIFO head is only valid after the previous pop settles, so each payload
        // byte is loaded in the quiet cycle that the strobe gap forces anyway.
        if (send) begin
          fifo_pop  = 1'b1;
          pending_d = 1'b0;
          remain_d  = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d   = StCsum;
            tx_data_d = csum_q ^ tx_data_q;
            pending_d = 1'b1;
          end
        end else if (!pending_q) begin
          tx_data_d = fifo_rdata;
          pending_d = 1'b1;
        end
      end
      StCsum: begin
        if (send) begin
          state_d   = StIdle;
          pending_d = 1'b0;
          seq_d     = seq_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      hdr_idx_q   <= 2'd0;
      remain_q    <= 8'd0;
      len_q       <= 8'd0;
      csum_q      <= 8'h00;
      seq_q       <= 8'h00;
      idle_cnt_q  <= '0;
      send_prev_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      tx_data_q   <= tx_data_d;
      hdr_idx_q   <= hdr_idx_d;
      remain_q    <= remain_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      seq_q       <= seq_d;
      idle_cnt_q  <= idle_cnt_d;
      send_prev_q <= send;
      overflow_q  <= data_valid & fifo_full;
    end
  end

endmodule
